// File: rtl/eth_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
//   pkt_mode_t     : payload source selector (counter / PRBS31 / fixed)
//   gen_state_t    : generator FSM encoding
//   PRBS_*         : PRBS31 polynomial x^31 + x^28 + 1 taps and seed
//   last_keep_mask : tkeep pattern for the final beat of a packet
package eth_pkt_gen_pkg;

    typedef enum logic [1:0] {
        COUNTER = 2'd0,
        PRBS31  = 2'd1,
        FIXED   = 2'd2
    } pkt_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_t;

    localparam int unsigned PRBS_LEN    = 31;
    localparam int unsigned PRBS_TAP_HI = 30;  // x^31 term
    localparam int unsigned PRBS_TAP_LO = 27;  // x^28 term
    localparam logic [PRBS_LEN-1:0] PRBS_SEED = '1;

    // rem is bytes mod BPB; caller keeps the low BPB bits of the result.
    function automatic logic [7:0] last_keep_mask(input logic [2:0] rem);
        logic [7:0] m;
        if (rem == 3'd0) begin
            m = 8'hFF;
        end else begin
            m = (8'h01 << rem) - 8'h01;
        end
        return m;
    endfunction

endpackage

// File: rtl/prbs_gen.sv
// PRBS31 word generator (x^31 + x^28 + 1), OUT_WIDTH new bits per advance.
//   clk, reset : clock and synchronous active-high reset (state -> all ones)
//   advance    : consume the current word and step the LFSR by OUT_WIDTH bits
//   data       : word for the next consumer, first-generated bit in the MSB
module prbs_gen
    import eth_pkt_gen_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance,
    output logic [OUT_WIDTH-1:0] data
);

    logic [PRBS_LEN-1:0] state_q, state_d;

    function automatic logic [PRBS_LEN-1:0] step_state(input logic [PRBS_LEN-1:0] s);
        logic [PRBS_LEN-1:0] t;
        t = s;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            t = {t[PRBS_LEN-2:0], t[PRBS_TAP_HI] ^ t[PRBS_TAP_LO]};
        end
        return t;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] word_of(input logic [PRBS_LEN-1:0] s);
        logic [PRBS_LEN-1:0]  t;
        logic [OUT_WIDTH-1:0] w;
        t = s;
        w = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w = {w[OUT_WIDTH-2:0], t[PRBS_TAP_HI] ^ t[PRBS_TAP_LO]};
            t = {t[PRBS_LEN-2:0], t[PRBS_TAP_HI] ^ t[PRBS_TAP_LO]};
        end
        return w;
    endfunction

    // data follows state_d so a consumer registering it on the advancing edge
    // picks up the fresh word rather than the one just consumed.
    always_comb begin
        state_d = advance ? step_state(state_q) : state_q;
        data    = word_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PRBS_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/eth_packet_gen.sv
// AXI-Stream traffic generator for the MAC TX path.
//   start/stop        : run control; start accepted only when idle, stop ends at a packet boundary
//   cfg_*             : mode, packet bytes, inter-packet gap, packet count, fixed payload
//   m_axis_*          : AXI-Stream master, all outputs registered
//   busy/done         : busy in SEND or GAP; done pulses once when a run ends
//   pkts_sent         : packets completed since the last accepted start
// tdata[15:0] is the zero-based beat index; upper bits come from the selected payload mode.
module eth_packet_gen
    import eth_pkt_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              cfg_mode,
    input  logic [LEN_WIDTH-1:0]    cfg_pkt_bytes,
    input  logic [LEN_WIDTH-1:0]    cfg_gap,
    input  logic [LEN_WIDTH-1:0]    cfg_num_pkts,
    input  logic [DATA_WIDTH-17:0]  cfg_fixed_data,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    pkts_sent
);

    localparam int unsigned BPB = DATA_WIDTH / 8;
    localparam int unsigned BSH = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int unsigned UW  = DATA_WIDTH - 16;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_GAP  = GAP;

    localparam logic [1:0] MODE_COUNTER = COUNTER;
    localparam logic [1:0] MODE_PRBS    = PRBS31;
    localparam logic [1:0] MODE_FIXED   = FIXED;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [UW-1:0]         fixed_q, fixed_d;
    logic [LEN_WIDTH-1:0]  gap_q, gap_d;
    logic [LEN_WIDTH-1:0]  num_q, num_d;
    logic [LEN_WIDTH-1:0]  last_beat_q, last_beat_d;
    logic [BPB-1:0]        last_keep_q, last_keep_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    // Also serves as the packet sequence number: both clear on start and
    // step on every tlast handshake.
    logic [LEN_WIDTH-1:0]  pkts_sent_q, pkts_sent_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [BPB-1:0]        tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  hs;
    logic [UW-1:0]         prbs_data;
    logic [LEN_WIDTH-1:0]  start_bytes;
    logic [LEN_WIDTH-1:0]  start_last_beat;
    logic [BPB-1:0]        start_last_keep;
    logic [1:0]            start_mode;
    logic [LEN_WIDTH-1:0]  next_pkts;

    assign hs = tvalid_q & m_axis_tready;

    prbs_gen #(
        .OUT_WIDTH(UW)
    ) u_prbs (
        .clk    (clk),
        .reset  (reset),
        .advance(hs),
        .data   (prbs_data)
    );

    function automatic logic [UW-1:0] payload_hi(
        input logic [1:0]           mode,
        input logic [LEN_WIDTH-1:0] seq,
        input logic [UW-1:0]        prbs,
        input logic [UW-1:0]        fixed
    );
        logic [UW-1:0] p;
        case (mode)
            MODE_PRBS:  p = prbs;
            MODE_FIXED: p = fixed;
            default:    p = UW'(seq);
        endcase
        return p;
    endfunction

    // Packet geometry derived from the live cfg inputs, latched on start.
    always_comb begin
        start_bytes     = (cfg_pkt_bytes == '0) ? LEN_ONE : cfg_pkt_bytes;
        start_last_beat = (start_bytes - LEN_ONE) >> BSH;
        start_last_keep = BPB'(last_keep_mask(3'(start_bytes[BSH-1:0])));
        start_mode      = (cfg_mode == 2'd3) ? MODE_COUNTER : cfg_mode;
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fixed_d     = fixed_q;
        gap_d       = gap_q;
        num_d       = num_q;
        last_beat_d = last_beat_q;
        last_keep_d = last_keep_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        pkts_sent_d = pkts_sent_q;
        stop_pend_d = stop_pend_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        next_pkts   = pkts_sent_q + LEN_ONE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = start_mode;
                    fixed_d     = cfg_fixed_data;
                    gap_d       = cfg_gap;
                    num_d       = cfg_num_pkts;
                    last_beat_d = start_last_beat;
                    last_keep_d = start_last_keep;
                    beat_d      = '0;
                    pkts_sent_d = '0;
                    stop_pend_d = stop;
                    state_d     = ST_SEND;
                    tvalid_d    = 1'b1;
                    busy_d      = 1'b1;
                    tdata_d     = {payload_hi(start_mode, '0, prbs_data, cfg_fixed_data), 16'h0000};
                    tlast_d     = (start_last_beat == '0);
                    tkeep_d     = tlast_d ? start_last_keep : '1;
                end
            end

            ST_SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (hs) begin
                    if (tlast_q) begin
                        pkts_sent_d = next_pkts;
                        if (stop_pend_q || stop || (num_q != '0 && next_pkts == num_q)) begin
                            state_d     = ST_IDLE;
                            tvalid_d    = 1'b0;
                            tlast_d     = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else if (gap_q == '0) begin
                            beat_d  = '0;
                            tdata_d = {payload_hi(mode_q, next_pkts, prbs_data, fixed_q), 16'h0000};
                            tlast_d = (last_beat_q == '0);
                            tkeep_d = tlast_d ? last_keep_q : '1;
                        end else begin
                            state_d   = ST_GAP;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d  = beat_q + LEN_ONE;
                        tdata_d = {payload_hi(mode_q, pkts_sent_q, prbs_data, fixed_q),
                                   16'(beat_d)};
                        tlast_d = (beat_d == last_beat_q);
                        tkeep_d = tlast_d ? last_keep_q : '1;
                    end
                end
            end

            ST_GAP: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q <= LEN_ONE) begin
                    // Last idle cycle: tvalid rises next cycle, giving exactly cfg_gap idles.
                    state_d  = ST_SEND;
                    tvalid_d = 1'b1;
                    beat_d   = '0;
                    tdata_d  = {payload_hi(mode_q, pkts_sent_q, prbs_data, fixed_q), 16'h0000};
                    tlast_d  = (last_beat_q == '0);
                    tkeep_d  = tlast_d ? last_keep_q : '1;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_COUNTER;
            fixed_q     <= '0;
            gap_q       <= '0;
            num_q       <= '0;
            last_beat_q <= '0;
            last_keep_q <= '0;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            pkts_sent_q <= '0;
            stop_pend_q <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fixed_q     <= fixed_d;
            gap_q       <= gap_d;
            num_q       <= num_d;
            last_beat_q <= last_beat_d;
            last_keep_q <= last_keep_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            pkts_sent_q <= pkts_sent_d;
            stop_pend_q <= stop_pend_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkts_sent     = pkts_sent_q;

endmodule
